// File: rtl/mmio_seg_display_pkg.sv
// Shared constants for the memory-mapped seven-segment/LED peripheral.
package mmio_seg_display_pkg;

   // Register select, decoded from mem_addr[3:2]
   typedef enum logic [1:0] {
      REG_LED    = 2'd0,
      REG_DISP   = 2'd1,
      REG_CTRL   = 2'd2,
      REG_STATUS = 2'd3
   } reg_off_e;

   // CTRL field positions
   localparam int unsigned CTRL_EN_BIT     = 0;
   localparam int unsigned CTRL_BLZ_BIT    = 1;
   localparam int unsigned CTRL_BRIGHT_LSB = 2;
   localparam int unsigned CTRL_W          = 6;

   // en=1, blank_lz=0, bright=15
   localparam logic [CTRL_W-1:0] CTRL_RESET = 6'h3D;

   // Active-high {g,f,e,d,c,b,a} patterns, entry 15 (F) first down to entry 0
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/mmio_seg_display_if.sv
// Processor data-bus bundle seen by the display peripheral.
interface mmio_seg_display_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb;
   logic [31:0] mem_rdata;

   modport master (
      output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
      output mem_rdata
   );
endinterface

// File: rtl/mmio_seg_display_hex.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_7seg
   import mmio_seg_display_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] pat
);
   assign pat = SEG_LUT[nib];
endmodule

// File: rtl/mmio_seg_display.sv
// Memory-mapped LED driver and multiplexed hex display with leading-zero
// blanking, brightness PWM and frame-synchronous (tear-free) value updates.
module mmio_seg_display
   import mmio_seg_display_pkg::*;
#(
   parameter int unsigned N_DIGITS       = 2,
   parameter int unsigned N_LEDS         = 4,
   parameter int unsigned REFRESH_DIV    = 12,
   parameter logic [31:0] BASE_ADDR      = 32'h0040_0000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                RESET,
   mmio_seg_display_if.slave   bus,
   output logic [N_LEDS-1:0]   leds,
   output logic [6:0]          seg,
   output logic [N_DIGITS-1:0] digit_en
);
   localparam int unsigned DW = 4 * N_DIGITS;
   localparam logic [6:0]          SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic [N_DIGITS-1:0] DEN_OFF = {N_DIGITS{SEG_ACTIVE_LOW}};
   localparam logic [2:0]          CD_LAST = 3'(N_DIGITS - 1);

   logic [N_LEDS-1:0]      led_reg, led_nx;
   logic [DW-1:0]          shadow, shadow_nx, active;
   logic [CTRL_W-1:0]      ctrl, ctrl_nx;
   logic [REFRESH_DIV-1:0] prescaler;
   logic [2:0]             cur_digit;
   logic                   sticky;

   logic     sel, wr, rd, tick, frame_end;
   reg_off_e off;
   logic     unused_bits;

   assign sel       = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
   assign off       = reg_off_e'(bus.mem_addr[3:2]);
   assign wr        = sel && (|bus.mem_wmask);
   assign rd        = sel && bus.mem_rstrb;
   assign tick      = &prescaler;
   assign frame_end = tick && (cur_digit == CD_LAST);
   assign leds      = led_reg;
   assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata};

   // Byte-lane merge of write data into each register at its own width
   always_comb begin
      led_nx    = led_reg;
      shadow_nx = shadow;
      ctrl_nx   = ctrl;
      for (int unsigned b = 0; b < N_LEDS; b++)
         if (bus.mem_wmask[b / 8]) led_nx[b] = bus.mem_wdata[b];
      for (int unsigned b = 0; b < DW; b++)
         if (bus.mem_wmask[b / 8]) shadow_nx[b] = bus.mem_wdata[b];
      if (bus.mem_wmask[0]) ctrl_nx = bus.mem_wdata[CTRL_W-1:0];
   end

   // CPU-writable registers; STATUS writes fall through and are dropped
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         led_reg <= '0;
         shadow  <= '0;
         ctrl    <= CTRL_RESET;
      end else if (wr) begin
         case (off)
            REG_LED:  led_reg <= led_nx;
            REG_DISP: shadow  <= shadow_nx;
            REG_CTRL: ctrl    <= ctrl_nx;
            default:  ;
         endcase
      end
   end

   // Scan timing, frame-end shadow transfer and frame sticky flag
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         prescaler <= '0;
         cur_digit <= '0;
         active    <= '0;
         sticky    <= 1'b0;
      end else begin
         prescaler <= prescaler + 1'b1;
         if (tick) cur_digit <= frame_end ? 3'd0 : cur_digit + 3'd1;
         if (frame_end) active <= shadow;
         // a frame-end set takes priority over the clear-on-read
         if (frame_end) sticky <= 1'b1;
         else if (rd && off == REG_STATUS) sticky <= 1'b0;
      end
   end

   // Registered read port, holds between strobes
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         bus.mem_rdata <= '0;
      end else if (rd) begin
         case (off)
            REG_LED:    bus.mem_rdata <= 32'(led_reg);
            REG_DISP:   bus.mem_rdata <= 32'(shadow);
            REG_CTRL:   bus.mem_rdata <= 32'(ctrl);
            REG_STATUS: bus.mem_rdata <= {23'd0, sticky | frame_end, 5'd0, cur_digit};
            default:    bus.mem_rdata <= '0;
         endcase
      end
   end

   logic [3:0]          nib;
   logic [6:0]          pat;
   logic [N_DIGITS-1:0] den_hot;
   logic                upper_zero, pwm_on, blank;

   hex_to_7seg u_hex (
      .nib (nib),
      .pat (pat)
   );

   // Current digit's nibble, leading-zero detect and PWM/enable blanking
   always_comb begin
      nib        = '0;
      den_hot    = '0;
      upper_zero = 1'b1;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if (cur_digit == 3'(i)) begin
            nib        = active[4*i +: 4];
            den_hot[i] = 1'b1;
         end
         if (32'(cur_digit) <= i && active[4*i +: 4] != 4'd0) upper_zero = 1'b0;
      end
      pwm_on = (prescaler[REFRESH_DIV-1 -: 4] <= ctrl[CTRL_BRIGHT_LSB +: 4]);
      blank  = !ctrl[CTRL_EN_BIT] || !pwm_on ||
               (ctrl[CTRL_BLZ_BIT] && cur_digit != 3'd0 && upper_zero);
   end

   // Output stage, one cycle behind the scan state, polarity applied here
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         seg      <= SEG_OFF;
         digit_en <= DEN_OFF;
      end else begin
         seg      <= blank ? SEG_OFF : (pat ^ SEG_OFF);
         digit_en <= blank ? DEN_OFF : (den_hot ^ DEN_OFF);
      end
   end
endmodule

// File: doc/mmio_seg_display.md
Name: mmio_seg_display

Overview:
- Memory-mapped display/LED peripheral for the SOC: the processor writes LED, display-value and control registers over the data bus.
- The block drives N_LEDS LEDs directly and time-multiplexes an N_DIGITS hex seven-segment display.
- Adds leading-zero blanking, brightness PWM and tear-free display updates.
- Sits between the Processor data bus and board pins; clocked by the Clockworks-derived clk.

Parameters:
- N_DIGITS, 2, number of multiplexed 7-seg digits (1..8); display value width is 4*N_DIGITS.
- N_LEDS, 4, number of discrete LEDs (1..32).
- REFRESH_DIV, 12, each digit slot lasts 2^REFRESH_DIV clk cycles (must be >= 4).
- BASE_ADDR, 32'h0040_0000, 16-byte-aligned register window base.
- SEG_ACTIVE_LOW, 1, 1 = segment and digit-enable outputs are active-low.

Ports:
- clk  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wmask  in  4  byte write enables
- mem_rstrb  in  1  read strobe
- mem_rdata  out  32  read data, registered
- leds  out  N_LEDS  LED drive, active-high
- seg  out  7  segments {g,f,e,d,c,b,a}
- digit_en  out  N_DIGITS  one-hot digit select

Behaviour:
- Interface rule: one clock (clk); reset (RESET) is asynchronous and active-high.
- Window select: sel = (mem_addr[31:4] == BASE_ADDR[31:4]). Offset mem_addr[3:2] picks the register.
- Registers:
  - 0x0 LED: bits [N_LEDS-1:0], read/write.
  - 0x4 DISP_SHADOW: bits [4*N_DIGITS-1:0], read/write.
  - 0x8 CTRL: bit0 en, bit1 blank_lz, bits[5:2] bright. Read/write.
  - 0xC STATUS: read-only; [2:0] cur_digit, [8] frame_tick_sticky. A read clears the sticky bit.
- Write: occurs on any cycle with sel and |mem_wmask. Each byte lane is written only if its mask bit is set. Unimplemented bits read 0. Writes to STATUS are ignored.
- Read: if mem_rstrb and sel, mem_rdata is updated at the next clk edge with the addressed register (latency 1). Otherwise mem_rdata holds its value.
- Reset values: LED=0, DISP_SHADOW=0, DISP_ACTIVE=0, CTRL = en 1, blank_lz 0, bright 15. Prescaler=0, cur_digit=0, sticky=0, mem_rdata=0. seg and digit_en are driven inactive (all 1 when SEG_ACTIVE_LOW).
- Scan:
  - A REFRESH_DIV-bit prescaler increments every cycle.
  - At all-ones, cur_digit advances by one, wrapping N_DIGITS-1 to 0.
  - When cur_digit wraps (frame end): DISP_ACTIVE <= DISP_SHADOW and sticky <= 1. This is the only path from shadow to display, so no tearing.
  - A same-cycle CPU write to DISP_SHADOW at a frame end: the old shadow is transferred; the new value appears next frame.
  - A STATUS read in the same cycle as a frame-end set: the read returns 1 and sticky remains 1 (set wins).
- Output pipeline, registered, 1 cycle after scan state:
  - nib = DISP_ACTIVE[4*cur_digit +: 4], passed to hex decode.
  - PWM on = (prescaler[REFRESH_DIV-1 -: 4] <= bright). bright=15 is full on; bright=0 is 1/16 duty.
  - Blank when: en==0, or PWM off, or (blank_lz and cur_digit>0 and all nibbles at index >= cur_digit are 0). Digit 0 is never zero-blanked.
  - When not blanked: digit_en one-hot on cur_digit, seg = decoded pattern. When blanked: digit_en all inactive, seg all off.
  - All polarities are applied per SEG_ACTIVE_LOW.
- Hex patterns: standard 0-9 and A,b,C,d,E,F (for example 0 → a..f on, g off; 8 → all on).
- leds = LED register, combinationally to pins; no latency beyond the register write.
- RESET asserted mid-frame: all state clears immediately (asynchronous) and outputs go inactive. Scan restarts at digit 0 one cycle after release.

Decomposition:
- Shared package: register offsets (0x0/0x4/0x8/0xC), CTRL bit positions, the 16-entry seg pattern constants, and the CTRL reset value.
- One sub-module: hex_to_7seg, a combinational 4-bit → 7-bit pattern decoder. Polarity is applied in the parent.

Test Plan:
- Reset, then read CTRL (rstrb at 0x8) → mem_rdata=0x3D the next cycle; leds=0; digit_en=2'b11, seg=7'h7F (active-low).
- Write 0x4 = 0x0000_00A5 with wmask 4'b0001 → after the next frame end, digit0 seg shows 5 (0x12 active-low) and digit1 shows A (0x08). Before the frame end, DISP_ACTIVE is still 0.
- Write 0x4 with wmask 4'b0010, data 0x0000_FF00 → shadow 0xFFA5 masked to width, so the read back returns 0x00A5 for N_DIGITS=2 (byte1 outside the implemented bits).
- blank_lz=1, value 0x05 → digit1 is never enabled across 2 frames; digit0 shows 5.
- bright=0, REFRESH_DIV=4 → digit active exactly 1 of 16 cycles per slot. bright=15 → 16 of 16.
- Write LED=0x7 then assert RESET mid-slot → leds=0 and digit_en inactive in the same cycle (asynchronous); STATUS cur_digit=0 after release.
